// File: rtl/mtcmos_pwr_seq_ctrl_pkg.sv
// Shared types for the MTCMOS power sequencer: state encoding, default timings
// and the state-to-output decode.
package mtcmos_pwr_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    ISO     = 3'd1,
    SAVE    = 3'd2,
    OFF     = 3'd3,
    WAKE    = 3'd4,
    RESTORE = 3'd5
  } pwr_state_t;

  localparam int ISO_CYCLES_DEF    = 2;
  localparam int SETTLE_CYCLES_DEF = 8;

  typedef struct packed {
    logic iso_en;
    logic ret_save;
    logic ret_restore;
    logic sleep;
    logic pwr_ack;
    logic busy;
  } pwr_out_t;

  function automatic pwr_out_t decode_outs(input pwr_state_t s);
    pwr_out_t o;
    o = '0;
    case (s)
      ACTIVE:  o = 6'b000000;
      ISO:     o = 6'b100001;
      SAVE:    o = 6'b110001;
      OFF:     o = 6'b100110;
      WAKE:    o = 6'b100011;
      RESTORE: o = 6'b101011;
      default: o = 6'b000000;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mtcmos_pwr_seq_ctrl_if.sv
// Power-manager handshake plus domain control bundle for one gated domain.
interface mtcmos_pwr_seq_ctrl_if #(
  parameter int STAT_W = 16
);
  logic              pwr_req;
  logic              clr_stats;
  logic              pwr_ack;
  logic              busy;
  logic              iso_en;
  logic              ret_save;
  logic              ret_restore;
  logic              sleep;
  logic [STAT_W-1:0] sleep_cycles;

  modport master (
    output pwr_req, clr_stats,
    input  pwr_ack, busy, iso_en, ret_save, ret_restore, sleep, sleep_cycles
  );

  modport slave (
    input  pwr_req, clr_stats,
    output pwr_ack, busy, iso_en, ret_save, ret_restore, sleep, sleep_cycles
  );
endinterface

// File: rtl/mtcmos_pwr_seq_ctrl_timer.sv
// Loadable down-counter used to time the isolation and rail-settle phases.
module mtcmos_pwr_seq_ctrl_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mtcmos_pwr_seq_ctrl.sv
// Sequences an MTCMOS flip-flop domain through isolate/save/sleep and
// wake/restore, and counts cycles spent powered off.
module mtcmos_pwr_seq_ctrl
  import mtcmos_pwr_seq_ctrl_pkg::*;
#(
  parameter int ISO_CYCLES    = ISO_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = 8,
  parameter int STAT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mtcmos_pwr_seq_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0]  ISO_LOAD    = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_MAX    = {STAT_W{1'b1}};

  pwr_state_t        r_state;
  pwr_state_t        w_nxt;
  pwr_out_t          r_out;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_dec;
  logic              w_zero;
  logic [STAT_W-1:0] r_sleep_cycles;

  mtcmos_pwr_seq_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Only ACTIVE and OFF look at pwr_req, so in-flight sequences never abort.
  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      ACTIVE: if (bus.pwr_req) begin
        w_nxt      = ISO;
        w_load     = 1'b1;
        w_load_val = ISO_LOAD;
      end
      ISO: if (w_zero) w_nxt = SAVE; else w_dec = 1'b1;
      SAVE: w_nxt = OFF;
      OFF: if (!bus.pwr_req) begin
        w_nxt      = WAKE;
        w_load     = 1'b1;
        w_load_val = SETTLE_LOAD;
      end
      WAKE: if (w_zero) w_nxt = RESTORE; else w_dec = 1'b1;
      RESTORE: w_nxt = ACTIVE;
      default: w_nxt = ACTIVE;
    endcase
  end

  // Outputs are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACTIVE;
      r_out   <= '0;
    end else begin
      r_state <= w_nxt;
      r_out   <= decode_outs(w_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sleep_cycles <= '0;
    end else if (bus.clr_stats) begin
      r_sleep_cycles <= '0;
    end else if ((r_state == OFF) && (r_sleep_cycles != STAT_MAX)) begin
      r_sleep_cycles <= r_sleep_cycles + 1'b1;
    end
  end

  assign bus.iso_en       = r_out.iso_en;
  assign bus.ret_save     = r_out.ret_save;
  assign bus.ret_restore  = r_out.ret_restore;
  assign bus.sleep        = r_out.sleep;
  assign bus.pwr_ack      = r_out.pwr_ack;
  assign bus.busy         = r_out.busy;
  assign bus.sleep_cycles = r_sleep_cycles;

endmodule

// File: tb/tb_mtcmos_pwr_seq_ctrl.sv
// Directed bench for the MTCMOS power sequencer, with a second narrow-stats
// instance sharing the same stimulus.
module tb_mtcmos_pwr_seq_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mtcmos_pwr_seq_ctrl_if #(.STAT_W(16)) u_bus  ();
  mtcmos_pwr_seq_ctrl_if #(.STAT_W(4))  u_bus4 ();

  assign u_bus4.pwr_req   = u_bus.pwr_req;
  assign u_bus4.clr_stats = u_bus.clr_stats;

  mtcmos_pwr_seq_ctrl #(.STAT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus)
  );

  mtcmos_pwr_seq_ctrl #(.STAT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pattern order: iso/save/restore/sleep/ack/busy
  task automatic check_outs(input string tag, input logic [5:0] exp);
    check(tag, 32'({u_bus.iso_en, u_bus.ret_save, u_bus.ret_restore,
                    u_bus.sleep, u_bus.pwr_ack, u_bus.busy}), 32'(exp));
  endtask

  logic prev_save;
  logic prev_rest;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    u_bus.pwr_req   = 1'b0;
    u_bus.clr_stats = 1'b0;
    repeat (2) tick();
    check_outs("reset_outs", 6'b000000);
    check("reset_stats", 32'(u_bus.sleep_cycles), 32'd0);
    rst_n = 1'b1;
    tick();
    check_outs("idle_active", 6'b000000);

    // Power-down sequence
    u_bus.pwr_req = 1'b1;
    tick();
    check_outs("down_e0_iso", 6'b100001);
    tick();
    check_outs("down_e1_iso", 6'b100001);
    tick();
    check_outs("down_e2_save", 6'b110001);
    tick();
    check_outs("down_e3_off", 6'b100110);
    check("off_entry_stats", 32'(u_bus.sleep_cycles), 32'd0);

    // Hold OFF 20 cycles; narrow counter saturates
    repeat (20) tick();
    check_outs("hold_off", 6'b100110);
    check("stats_20", 32'(u_bus.sleep_cycles), 32'd20);
    check("stats4_sat", 32'(u_bus4.sleep_cycles), 32'd15);
    u_bus.clr_stats = 1'b1;
    tick();
    check("stats_clr_in_off", 32'(u_bus.sleep_cycles), 32'd0);
    check("stats4_clr_in_off", 32'(u_bus4.sleep_cycles), 32'd0);
    u_bus.clr_stats = 1'b0;

    // Power-up sequence
    u_bus.pwr_req = 1'b0;
    tick();
    check_outs("up_e0_wake", 6'b100011);
    check("up_e0_stats", 32'(u_bus.sleep_cycles), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check_outs($sformatf("up_e%0d_wake", i), 6'b100011);
    end
    tick();
    check_outs("up_e8_restore", 6'b101011);
    tick();
    check_outs("up_e9_active", 6'b000000);
    check("up_stats_hold", 32'(u_bus.sleep_cycles), 32'd1);

    // Single-cycle request glitch
    u_bus.clr_stats = 1'b1;
    tick();
    u_bus.clr_stats = 1'b0;
    check("glitch_pre_clr", 32'(u_bus.sleep_cycles), 32'd0);
    u_bus.pwr_req = 1'b1;
    tick();
    u_bus.pwr_req = 1'b0;
    check_outs("glitch_e0_iso", 6'b100001);
    tick();
    check_outs("glitch_e1_iso", 6'b100001);
    tick();
    check_outs("glitch_e2_save", 6'b110001);
    tick();
    check_outs("glitch_e3_off", 6'b100110);
    tick();
    check_outs("glitch_e4_wake", 6'b100011);
    for (int i = 5; i < 12; i++) tick();
    check_outs("glitch_e11_wake", 6'b100011);
    tick();
    check_outs("glitch_e12_restore", 6'b101011);
    tick();
    check_outs("glitch_e13_active", 6'b000000);
    check("glitch_stats", 32'(u_bus.sleep_cycles), 32'd1);

    // Request raised mid-WAKE is ignored until ACTIVE
    u_bus.pwr_req = 1'b1;
    repeat (4) tick();
    u_bus.pwr_req = 1'b0;
    repeat (3) tick();
    u_bus.pwr_req = 1'b1;
    tick();
    check_outs("wake_ignores_req", 6'b100011);
    check("pre_reset_stats", 32'(u_bus.sleep_cycles), 32'd2);

    // Asynchronous reset mid-WAKE
    rst_n = 1'b0;
    u_bus.pwr_req = 1'b0;
    #1;
    check_outs("async_reset_outs", 6'b000000);
    check("async_reset_stats", 32'(u_bus.sleep_cycles), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_outs("post_reset_active", 6'b000000);
    tick();
    check_outs("post_reset_stays", 6'b000000);

    // Random request traffic with ordering invariants
    prev_save = 1'b0;
    prev_rest = 1'b0;
    for (int i = 0; i < 400; i++) begin
      u_bus.pwr_req = 1'($urandom_range(0, 1));
      tick();
      check("ord_save_iso", 32'(!u_bus.ret_save || u_bus.iso_en), 32'd1);
      check("ord_sleep_iso", 32'(!u_bus.sleep || u_bus.iso_en), 32'd1);
      check("ord_rest_iso", 32'(!u_bus.ret_restore || u_bus.iso_en), 32'd1);
      check("ord_rest_sleep", 32'(u_bus.ret_restore && u_bus.sleep), 32'd0);
      check("strobe_save_1cyc", 32'(prev_save && u_bus.ret_save), 32'd0);
      check("strobe_rest_1cyc", 32'(prev_rest && u_bus.ret_restore), 32'd0);
      prev_save = u_bus.ret_save;
      prev_rest = u_bus.ret_restore;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
